// File: rtl/link_pkg.sv
// Shared link-layer constants: monitor state encodings and ack_nak codes.
// Also imported by the transaction FSM so both sides agree on the ack_nak encoding.
package link_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_LOCK = 2'b10
  } mon_state_t;

  localparam logic [1:0] AN_NONE = 2'b00;
  localparam logic [1:0] AN_ACK  = 2'b01;
  localparam logic [1:0] AN_NAK  = 2'b10;

  localparam logic [7:0] ACK_CODE_DEF = 8'h06;
  localparam logic [7:0] NAK_CODE_DEF = 8'h15;

  // Saturating increment used for the retry counter; never wraps past lim.
  function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
    return (v >= lim) ? lim : v + 2'd1;
  endfunction

endpackage

// File: rtl/resp_timer.sv
// Free-running TW-bit counter with clear/enable and an equality terminal-count flag.
// Clear wins over enable; o_tc is combinational from the registered count, no backpressure.
module resp_timer #(
  parameter int             TW   = 16,
  parameter logic [TW-1:0]  TERM = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_tc = (r_cnt == TERM);

endmodule

// File: rtl/resp_monitor.sv
// Arms on we, decodes ACK/NAK from rx bytes, times out after TIMEOUT_CYC cycles, tracks retries.
// All outputs registered (one-cycle latency); no backpressure, rx bytes outside WAIT are dropped.
module resp_monitor
  import link_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1000,
  parameter int         TW          = 16,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] ACK_CODE    = ACK_CODE_DEF,
  parameter logic [7:0] NAK_CODE    = NAK_CODE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       clr,
  output logic [1:0] ack_nak,
  output logic       tim_out,
  output logic       armed,
  output logic [1:0] retry_cnt,
  output logic       give_up
);

  localparam logic [TW-1:0] TMR_TERM  = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  mon_state_t r_state;
  logic [1:0] r_ack_nak;
  logic       r_tim_out;
  logic       r_armed;
  logic [1:0] r_retry;
  logic       r_give_up;

  logic       w_tc;
  logic       w_tmr_clr;
  logic       w_tmr_en;
  logic       w_ack;
  logic       w_nak;
  logic [1:0] w_retry_base;
  logic [1:0] w_retry_inc;
  logic       w_hit_max;

  assign w_tmr_clr    = we && (r_state != S_LOCK);
  assign w_tmr_en     = (r_state == S_WAIT);
  assign w_ack        = rx_valid && (rx_data == ACK_CODE);
  assign w_nak        = rx_valid && (rx_data == NAK_CODE);
  // clr in the same cycle as a failure means the failure counts from zero.
  assign w_retry_base = clr ? 2'd0 : r_retry;
  assign w_retry_inc  = sat_inc(w_retry_base, RETRY_MAX);
  assign w_hit_max    = (w_retry_inc == RETRY_MAX);

  resp_timer #(
    .TW   (TW),
    .TERM (TMR_TERM)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ack_nak <= AN_NONE;
      r_tim_out <= 1'b0;
      r_armed   <= 1'b0;
      r_retry   <= 2'd0;
      r_give_up <= 1'b0;
    end else begin
      r_ack_nak <= AN_NONE;
      r_tim_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_retry <= w_retry_base;
          if (we) begin
            r_state <= S_WAIT;
            r_armed <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_ack) begin
            r_ack_nak <= AN_ACK;
            r_retry   <= 2'd0;
            r_state   <= we ? S_WAIT : S_IDLE;
            r_armed   <= we;
          end else if (w_nak || w_tc) begin
            // A decoded response outranks a coincident terminal count.
            if (w_nak) r_ack_nak <= AN_NAK;
            else       r_tim_out <= 1'b1;
            r_retry <= w_retry_inc;
            if (w_hit_max) begin
              r_give_up <= 1'b1;
              r_state   <= S_LOCK;
              r_armed   <= 1'b0;
            end else begin
              r_state <= we ? S_WAIT : S_IDLE;
              r_armed <= we;
            end
          end else begin
            r_retry <= w_retry_base;
          end
        end
        S_LOCK: begin
          if (clr) begin
            r_retry   <= 2'd0;
            r_give_up <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign ack_nak   = r_ack_nak;
  assign tim_out   = r_tim_out;
  assign armed     = r_armed;
  assign retry_cnt = r_retry;
  assign give_up   = r_give_up;

endmodule

// File: tb/tb_resp_monitor.sv
// Directed bench for resp_monitor with TIMEOUT_CYC=10, MAX_RETRY=3.
// "Cycle k" means the output state k rising edges after the edge that sampled we.
module tb_resp_monitor;

  logic       clk;
  logic       reset;
  logic       we;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       clr;
  logic [1:0] ack_nak;
  logic       tim_out;
  logic       armed;
  logic [1:0] retry_cnt;
  logic       give_up;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  resp_monitor #(
    .TIMEOUT_CYC (10),
    .TW          (16),
    .MAX_RETRY   (3),
    .ACK_CODE    (8'h06),
    .NAK_CODE    (8'h15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .clr       (clr),
    .ack_nak   (ack_nak),
    .tim_out   (tim_out),
    .armed     (armed),
    .retry_cnt (retry_cnt),
    .give_up   (give_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] an, input logic to,
                         input logic ar, input logic [1:0] rc, input logic gu);
    chk({tag, ".ack_nak"},   8'(ack_nak),   8'(an));
    chk({tag, ".tim_out"},   8'(tim_out),   8'(to));
    chk({tag, ".armed"},     8'(armed),     8'(ar));
    chk({tag, ".retry_cnt"}, 8'(retry_cnt), 8'(rc));
    chk({tag, ".give_up"},   8'(give_up),   8'(gu));
  endtask

  task automatic rx(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; clr = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk_all("reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);

    // ACK path: rx ACK sampled at edge 6 -> pulse in cycle 6 only
    we = 1'b1; tick(); we = 1'b0;
    chk("ack.armed_c0", 8'(armed), 8'd1);
    for (int i = 1; i <= 5; i++) tick();
    chk("ack.none_c5", 8'(ack_nak), 8'd0);
    rx(1'b1, 8'h06); tick(); rx(1'b0, 8'h00);
    chk_all("ack.c6", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    chk("ack.c7_gone", 8'(ack_nak), 8'd0);

    // Timeout path with a non-code byte in the middle of WAIT
    we = 1'b1; tick(); we = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) rx(1'b1, 8'h41);
      tick();
      rx(1'b0, 8'h00);
      chk($sformatf("to.quiet_c%0d", i), 8'({ack_nak, tim_out}), 8'd0);
    end
    chk("to.armed_c9", 8'(armed), 8'd1);
    tick();
    chk_all("to.c10", 2'b00, 1'b1, 1'b0, 2'd1, 1'b0);
    tick();
    chk("to.c11_gone", 8'(tim_out), 8'd0);

    // clr in IDLE clears the retry count
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_idle.retry", 8'(retry_cnt), 8'd0);

    // Give-up: NAK, timeout, NAK
    we = 1'b1; tick(); we = 1'b0;
    rx(1'b1, 8'h15); tick(); rx(1'b0, 8'h00);
    chk_all("gu.nak1", 2'b10, 1'b0, 1'b0, 2'd1, 1'b0);
    we = 1'b1; tick(); we = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    chk_all("gu.to2", 2'b00, 1'b1, 1'b0, 2'd2, 1'b0);
    we = 1'b1; tick(); we = 1'b0;
    rx(1'b1, 8'h15); tick(); rx(1'b0, 8'h00);
    chk_all("gu.nak3", 2'b10, 1'b0, 1'b0, 2'd3, 1'b1);
    we = 1'b1; tick(); we = 1'b0;
    rx(1'b1, 8'h06); tick(); rx(1'b0, 8'h00);
    chk_all("gu.locked", 2'b00, 1'b0, 1'b0, 2'd3, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk_all("gu.clr", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);

    // Collision: ACK on the terminal-count edge
    we = 1'b1; tick(); we = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    rx(1'b1, 8'h06); tick(); rx(1'b0, 8'h00);
    chk_all("coll.c10", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    chk("coll.c11", 8'({ack_nak, tim_out}), 8'd0);

    // Re-arm at cycle 6 moves the timeout to cycle 16
    we = 1'b1; tick(); we = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    we = 1'b1; tick(); we = 1'b0;
    chk("rearm.c6", 8'({armed, tim_out}), 8'b10);
    for (int i = 7; i <= 15; i++) begin
      tick();
      chk($sformatf("rearm.quiet_c%0d", i), 8'(tim_out), 8'd0);
    end
    tick();
    chk_all("rearm.c16", 2'b00, 1'b1, 1'b0, 2'd1, 1'b0);

    // we in the same cycle as a NAK re-arms after reporting
    we = 1'b1; tick();
    rx(1'b1, 8'h15); tick(); rx(1'b0, 8'h00); we = 1'b0;
    chk_all("nak_we", 2'b10, 1'b0, 1'b1, 2'd2, 1'b0);
    tick();
    chk("nak_we.next", 8'({ack_nak, armed}), 8'b001);

    // Reset while waiting, then a late ACK must not pulse
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all("rst_wait", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    rx(1'b1, 8'h06); tick(); rx(1'b0, 8'h00);
    chk("rst_wait.late_ack", 8'(ack_nak), 8'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rst_wait.no_to_%0d", i), 8'(tim_out), 8'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
